// File: rtl/arc4_engine.sv
// arc4_engine: ARC4 decrypt engine. It runs KSA and PRGA on an internal 256-byte S array.
//   It reads a length-prefixed ciphertext from ct memory and writes a length-prefixed plaintext to pt memory.
// Latency: rdy returns high 515+2L cycles after the accept edge, where L is the message length byte.
// Backpressure: none. While the engine is busy (rdy=0), en is ignored.
//   Memories are assumed always ready: ct read latency is 1 cycle, and pt accepts one write per cycle.
// Ports:
//   clk/rst    clock; asynchronous active-high reset
//   en/rdy     start request / idle. A run is accepted on the edge where en && rdy.
//   key        key, byte 0 in the MSBs. It is latched at accept.
//   ct_addr    ciphertext read port. ct_rddata is valid one cycle after ct_addr.
//   ct_rddata  ciphertext read data
//   pt_*       plaintext write port; pt_wren pulses once per byte
//   pt_ok      printable-plaintext flag. It is only live when ARC4_PRINTABLE_CHECK_EN is defined; otherwise it is tied to 0.
module arc4_engine #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_AW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [MSG_AW-1:0]      ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [MSG_AW-1:0]      pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren,
  output logic                   pt_ok
);

  localparam int KW = 8*KEY_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_KSA, ST_LEN_RD, ST_LEN_WR, ST_PRGA_A, ST_PRGA_B, ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          rdy_q, rdy_d;
  logic [KW-1:0] key_q, key_d;
  logic [7:0]    i_q, i_d;
  logic [7:0]    j_q, j_d;
  logic [7:0]    k_q, k_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    ct_addr_q, ct_addr_d;
  logic [7:0]    pt_addr_q, pt_addr_d;
  logic [7:0]    pt_wrdata_q, pt_wrdata_d;
  logic          pt_wren_q, pt_wren_d;
`ifdef ARC4_PRINTABLE_CHECK_EN
  logic          ok_q, ok_d;
`endif

  // S array: combinational read. Two write ports fire in the same cycle so a swap completes in one cycle.
  logic [7:0] s_mem [0:255];
  logic       s_we;
  logic [7:0] s_wa0, s_wd0, s_wa1, s_wd1;

  logic [7:0]    i_inc, ksa_j, prga_j, pad_idx, pad, pt_byte;
  logic [KW-1:0] key_rot;

  assign i_inc   = i_q + 8'd1;
  // key_q is rotated left one byte per KSA step, so the top byte is always key[i mod KEY_BYTES].
  assign ksa_j   = j_q + s_mem[i_q] + key_q[KW-1 -: 8];
  assign key_rot = (key_q << 8) | (key_q >> (KW-8));
  assign prga_j  = j_q + s_mem[i_inc];
  // In PRGA_B, i_q and j_q already hold the indices just swapped, so these reads see post-swap values.
  assign pad_idx = s_mem[i_q] + s_mem[j_q];
  assign pad     = s_mem[pad_idx];
  assign pt_byte = ct_rddata ^ pad;

  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    key_d       = key_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    len_d       = len_q;
    ct_addr_d   = ct_addr_q;
    pt_addr_d   = pt_addr_q;
    pt_wrdata_d = pt_wrdata_q;
    pt_wren_d   = 1'b0;
    s_we        = 1'b0;
    s_wa0       = i_q;
    s_wd0       = 8'd0;
    s_wa1       = i_q;
    s_wd1       = 8'd0;
`ifdef ARC4_PRINTABLE_CHECK_EN
    ok_d        = ok_q;
`endif
    case (state_q)
      ST_IDLE: begin
        rdy_d = 1'b1;
        if (en && rdy_q) begin
          key_d   = key;
          i_d     = 8'd0;
          j_d     = 8'd0;
          rdy_d   = 1'b0;
          state_d = ST_INIT;
`ifdef ARC4_PRINTABLE_CHECK_EN
          ok_d    = 1'b1;
`endif
        end
      end
      ST_INIT: begin
        s_we  = 1'b1;
        s_wd0 = i_q;
        s_wd1 = i_q;
        i_d   = i_inc;
        if (i_q == 8'hFF) state_d = ST_KSA;
      end
      ST_KSA: begin
        s_we  = 1'b1;
        s_wa0 = i_q;
        s_wd0 = s_mem[ksa_j];
        s_wa1 = ksa_j;
        s_wd1 = s_mem[i_q];
        j_d   = ksa_j;
        i_d   = i_inc;
        key_d = key_rot;
        if (i_q == 8'hFF) state_d = ST_LEN_RD;
      end
      ST_LEN_RD: begin
        // ct_addr is already 0 here, so the length byte arrives during LEN_WR.
        state_d = ST_LEN_WR;
      end
      ST_LEN_WR: begin
        len_d       = ct_rddata;
        i_d         = 8'd0;
        j_d         = 8'd0;
        pt_wren_d   = 1'b1;
        pt_addr_d   = 8'd0;
        pt_wrdata_d = ct_rddata;
        if (ct_rddata == 8'd0) begin
          state_d = ST_DONE;
        end else begin
          k_d       = 8'd1;
          ct_addr_d = 8'd1;
          state_d   = ST_PRGA_A;
        end
      end
      ST_PRGA_A: begin
        s_we    = 1'b1;
        s_wa0   = i_inc;
        s_wd0   = s_mem[prga_j];
        s_wa1   = prga_j;
        s_wd1   = s_mem[i_inc];
        i_d     = i_inc;
        j_d     = prga_j;
        state_d = ST_PRGA_B;
      end
      ST_PRGA_B: begin
        pt_wren_d   = 1'b1;
        pt_addr_d   = k_q;
        pt_wrdata_d = pt_byte;
`ifdef ARC4_PRINTABLE_CHECK_EN
        if (pt_byte < 8'h20 || pt_byte > 8'h7E) ok_d = 1'b0;
`endif
        if (k_q == len_q) begin
          // Park the read address at 0 so no later ct read lands above L.
          ct_addr_d = 8'd0;
          state_d   = ST_DONE;
        end else begin
          k_d       = k_q + 8'd1;
          ct_addr_d = k_q + 8'd1;
          state_d   = ST_PRGA_A;
        end
      end
      ST_DONE: begin
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b1;
      key_q       <= '0;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      k_q         <= 8'd0;
      len_q       <= 8'd0;
      ct_addr_q   <= 8'd0;
      pt_addr_q   <= 8'd0;
      pt_wrdata_q <= 8'd0;
      pt_wren_q   <= 1'b0;
`ifdef ARC4_PRINTABLE_CHECK_EN
      ok_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      key_q       <= key_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      len_q       <= len_d;
      ct_addr_q   <= ct_addr_d;
      pt_addr_q   <= pt_addr_d;
      pt_wrdata_q <= pt_wrdata_d;
      pt_wren_q   <= pt_wren_d;
`ifdef ARC4_PRINTABLE_CHECK_EN
      ok_q        <= ok_d;
`endif
    end
  end

  // S is not reset; INIT rewrites every entry before it is read.
  always_ff @(posedge clk) begin
    if (s_we) begin
      s_mem[s_wa0] <= s_wd0;
      s_mem[s_wa1] <= s_wd1;
    end
  end

  assign rdy       = rdy_q;
  assign ct_addr   = MSG_AW'(ct_addr_q);
  assign pt_addr   = MSG_AW'(pt_addr_q);
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;
`ifdef ARC4_PRINTABLE_CHECK_EN
  assign pt_ok     = ok_q;
`else
  assign pt_ok     = 1'b0;
`endif

endmodule

// File: tb/tb_arc4_engine.sv
`timescale 1ns/1ps
module tb_arc4_engine;

`ifdef ARC4_PRINTABLE_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  localparam logic [127:0] V_KEY_CT  = 128'h09BBF316E8D940AF0AD3;
  localparam logic [127:0] V_KEY_PT  = {48'h0, 8'h09, "Plaintext"};
  localparam logic [127:0] V_WIKI_CT = 128'h051021BF0420;
  localparam logic [127:0] V_WIKI_PT = {80'h0, 8'h05, "pedia"};
  localparam logic [127:0] V_ATK_CT  = 128'h0E45A01F645FC35B383552544B9BF5;
  localparam logic [127:0] V_ATK_PT  = {8'h0, 8'h0E, "Attack at dawn"};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en        [3];
  logic        rdy       [3];
  logic [23:0] key3;
  logic [31:0] key4;
  logic [47:0] key6;
  logic [7:0]  ct_addr   [3];
  logic [7:0]  ct_rddata [3];
  logic [7:0]  pt_addr   [3];
  logic [7:0]  pt_wrdata [3];
  logic        pt_wren   [3];
  logic        pt_ok     [3];

  arc4_engine #(.KEY_BYTES(3), .MSG_AW(8)) u_k3 (
    .clk(clk), .rst(rst), .en(en[0]), .rdy(rdy[0]), .key(key3),
    .ct_addr(ct_addr[0]), .ct_rddata(ct_rddata[0]), .pt_addr(pt_addr[0]),
    .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0]), .pt_ok(pt_ok[0]));
  arc4_engine #(.KEY_BYTES(4), .MSG_AW(8)) u_k4 (
    .clk(clk), .rst(rst), .en(en[1]), .rdy(rdy[1]), .key(key4),
    .ct_addr(ct_addr[1]), .ct_rddata(ct_rddata[1]), .pt_addr(pt_addr[1]),
    .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1]), .pt_ok(pt_ok[1]));
  arc4_engine #(.KEY_BYTES(6), .MSG_AW(8)) u_k6 (
    .clk(clk), .rst(rst), .en(en[2]), .rdy(rdy[2]), .key(key6),
    .ct_addr(ct_addr[2]), .ct_rddata(ct_rddata[2]), .pt_addr(pt_addr[2]),
    .pt_wrdata(pt_wrdata[2]), .pt_wren(pt_wren[2]), .pt_ok(pt_ok[2]));

  // Synchronous ct memories, one per instance.
  logic [7:0] ct_mem [3][256];
  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) ct_rddata[n] <= ct_mem[n][ct_addr[n]];
  end

  // Output monitor: records every pt write as {inst, addr, data} and the highest ct address seen.
  logic [17:0] obs_q [$];
  logic [17:0] exp_q [$];
  int          ct_max [3];
  always @(negedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (pt_wren[n] === 1'b1) obs_q.push_back({n[1:0], pt_addr[n], pt_wrdata[n]});
      if (int'(ct_addr[n]) > ct_max[n]) ct_max[n] = int'(ct_addr[n]);
    end
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pt [256];
  bit         m_ok;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ct(input int n, input logic [127:0] v, input int len);
    for (int b = 0; b < 256; b++) ct_mem[n][b] = 8'hA5;
    for (int b = 0; b < len; b++) ct_mem[n][b] = v[8*(len-1-b) +: 8];
  endtask

  task automatic push_exp(input int n, input logic [127:0] v, input int len);
    for (int b = 0; b < len; b++) exp_q.push_back({n[1:0], b[7:0], v[8*(len-1-b) +: 8]});
  endtask

  task automatic wait_rdy(input int n, input int budget, output int cyc);
    cyc = 0;
    while (rdy[n] !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  // Pops observed writes against the scoreboard. It reports the sizes, the number of mismatches, and the first bad pair.
  task automatic drain(output int nobs, output int nexp, output int nbad,
                       output logic [17:0] got, output logic [17:0] want);
    logic [17:0] o, e;
    nobs = obs_q.size();
    nexp = exp_q.size();
    nbad = 0;
    got  = '0;
    want = '0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        if (nbad == 0) begin
          got  = o;
          want = e;
        end
        nbad++;
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Reference ARC4 over the ct memory of instance n.
  task automatic rc4_model(input logic [127:0] k, input int kb, input int n);
    logic [7:0] s [256];
    logic [7:0] t, i, j;
    int len;
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    j = 8'd0;
    for (int x = 0; x < 256; x++) begin
      j = j + s[x] + k[8*(kb-1-(x%kb)) +: 8];
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    len = int'(ct_mem[n][0]);
    m_pt[0] = ct_mem[n][0];
    m_ok = 1'b1;
    i = 8'd0;
    j = 8'd0;
    for (int b = 1; b <= len; b++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      m_pt[b] = ct_mem[n][b] ^ s[8'(s[i] + s[j])];
      if (m_pt[b] < 8'h20 || m_pt[b] > 8'h7E) m_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int n = 0; n < 3; n++) begin
      checks++; if (rdy[n] !== 1'b1) begin errors++; $display("FAIL reset_rdy[%0d] got %b want 1", n, rdy[n]); end
      checks++; if (pt_wren[n] !== 1'b0) begin errors++; $display("FAIL reset_pt_wren[%0d] got %b want 0", n, pt_wren[n]); end
      checks++; if (pt_ok[n] !== 1'b0) begin errors++; $display("FAIL reset_pt_ok[%0d] got %b want 0", n, pt_ok[n]); end
      checks++; if (ct_addr[n] !== 8'h00) begin errors++; $display("FAIL reset_ct_addr[%0d] got %h want 00", n, ct_addr[n]); end
      checks++; if (pt_addr[n] !== 8'h00) begin errors++; $display("FAIL reset_pt_addr[%0d] got %h want 00", n, pt_addr[n]); end
      checks++; if (pt_wrdata[n] !== 8'h00) begin errors++; $display("FAIL reset_pt_wrdata[%0d] got %h want 00", n, pt_wrdata[n]); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_plaintext();
    int cyc, nobs, nexp, nbad;
    logic [17:0] got, want;
    load_ct(0, V_KEY_CT, 10);
    push_exp(0, V_KEY_PT, 10);
    key3 = "Key";
    ct_max[0] = 0;
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    key3 = 24'h0;  // changed after accept: must not affect this run
    wait_rdy(0, 2000, cyc);
    checks++; if (cyc !== 533) begin errors++; $display("FAIL key_latency got %0d want 533", cyc); end
    drain(nobs, nexp, nbad, got, want);
    checks++; if (nobs !== nexp) begin errors++; $display("FAIL key_writes got %0d want %0d", nobs, nexp); end
    checks++; if (nbad !== 0) begin errors++; $display("FAIL key_data got %h want %h (bad %0d)", got, want, nbad); end
    checks++; if (pt_ok[0] !== PCHK) begin errors++; $display("FAIL key_pt_ok got %b want %b", pt_ok[0], PCHK); end
    checks++; if (ct_max[0] !== 9) begin errors++; $display("FAIL key_ct_max got %0d want 9", ct_max[0]); end
  endtask

  task automatic test_pedia();
    int cyc, nobs, nexp, nbad;
    logic [17:0] got, want;
    load_ct(1, V_WIKI_CT, 6);
    push_exp(1, V_WIKI_PT, 6);
    key4 = "Wiki";
    ct_max[1] = 0;
    en[1] = 1'b1;
    tick();
    en[1] = 1'b0;
    wait_rdy(1, 2000, cyc);
    checks++; if (cyc !== 525) begin errors++; $display("FAIL wiki_latency got %0d want 525", cyc); end
    drain(nobs, nexp, nbad, got, want);
    checks++; if (nobs !== nexp) begin errors++; $display("FAIL wiki_writes got %0d want %0d", nobs, nexp); end
    checks++; if (nbad !== 0) begin errors++; $display("FAIL wiki_data got %h want %h (bad %0d)", got, want, nbad); end
    checks++; if (ct_max[1] !== 5) begin errors++; $display("FAIL wiki_ct_max got %0d want 5", ct_max[1]); end
  endtask

  task automatic test_attack();
    int cyc, nobs, nexp, nbad;
    logic [17:0] got, want;
    load_ct(2, V_ATK_CT, 15);
    push_exp(2, V_ATK_PT, 15);
    key6 = "Secret";
    en[2] = 1'b1;
    tick();
    en[2] = 1'b0;
    wait_rdy(2, 2000, cyc);
    checks++; if (cyc !== 543) begin errors++; $display("FAIL attack_latency got %0d want 543", cyc); end
    drain(nobs, nexp, nbad, got, want);
    checks++; if (nobs !== nexp) begin errors++; $display("FAIL attack_writes got %0d want %0d", nobs, nexp); end
    checks++; if (nbad !== 0) begin errors++; $display("FAIL attack_data got %h want %h (bad %0d)", got, want, nbad); end
    checks++; if (pt_ok[2] !== PCHK) begin errors++; $display("FAIL attack_pt_ok got %b want %b", pt_ok[2], PCHK); end
  endtask

  task automatic test_zero_len();
    int cyc, nobs, nexp, nbad;
    logic [17:0] got, want;
    load_ct(0, 128'h0, 1);
    push_exp(0, 128'h0, 1);
    key3 = "Key";
    ct_max[0] = 0;
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    wait_rdy(0, 2000, cyc);
    checks++; if (cyc !== 515) begin errors++; $display("FAIL zero_latency got %0d want 515", cyc); end
    drain(nobs, nexp, nbad, got, want);
    checks++; if (nobs !== 1) begin errors++; $display("FAIL zero_writes got %0d want 1", nobs); end
    checks++; if (nbad !== 0) begin errors++; $display("FAIL zero_data got %h want %h", got, want); end
    checks++; if (ct_max[0] !== 0) begin errors++; $display("FAIL zero_ct_max got %0d want 0", ct_max[0]); end
    checks++; if (pt_ok[0] !== PCHK) begin errors++; $display("FAIL zero_pt_ok got %b want %b", pt_ok[0], PCHK); end
  endtask

  task automatic test_wrong_key();
    int cyc, nobs, nexp, nbad, nsame;
    logic [17:0] got, want;
    load_ct(0, V_KEY_CT, 10);
    rc4_model(128'h0, 3, 0);
    for (int b = 0; b <= 9; b++) exp_q.push_back({2'd0, b[7:0], m_pt[b]});
    key3 = 24'h000000;
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    cyc = 0;
    while (rdy[0] !== 1'b1 && cyc < 2000) begin
      en[0] = (cyc == 100);  // pulse while busy: must be ignored
      tick();
      cyc++;
    end
    en[0] = 1'b0;
    checks++; if (cyc !== 533) begin errors++; $display("FAIL wrong_latency got %0d want 533", cyc); end
    nsame = 0;
    for (int b = 1; b < obs_q.size() && b <= 9; b++)
      if (obs_q[b][7:0] === V_KEY_PT[8*(9-b) +: 8]) nsame++;
    checks++; if (nsame === 9 || obs_q.size() !== 10) begin errors++; $display("FAIL wrong_differs got %0d equal bytes of %0d writes want <9 of 10", nsame, obs_q.size()); end
    drain(nobs, nexp, nbad, got, want);
    checks++; if (nbad !== 0 || nobs !== nexp) begin errors++; $display("FAIL wrong_data got %h want %h (bad %0d, writes %0d/%0d)", got, want, nbad, nobs, nexp); end
    checks++; if (pt_ok[0] !== (PCHK & m_ok)) begin errors++; $display("FAIL wrong_pt_ok got %b want %b", pt_ok[0], PCHK & m_ok); end
    tick();
    tick();
    tick();
    checks++; if (rdy[0] !== 1'b1 || obs_q.size() !== 0) begin errors++; $display("FAIL ignored_en got rdy=%b writes=%0d want rdy=1 writes=0", rdy[0], obs_q.size()); end
  endtask

  task automatic test_reset_mid_run();
    int cyc, nobs, nexp, nbad;
    logic [17:0] got, want;
    load_ct(0, V_KEY_CT, 10);
    key3 = "Key";
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    for (cyc = 1; cyc < 300; cyc++) tick();
    rst = 1'b1;
    #1;
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL midrst_rdy got %b want 1", rdy[0]); end
    checks++; if (pt_wren[0] !== 1'b0) begin errors++; $display("FAIL midrst_pt_wren got %b want 0", pt_wren[0]); end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 600; c++) tick();
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL midrst_writes got %0d want 0", obs_q.size()); end
    obs_q.delete();
    push_exp(0, V_KEY_PT, 10);
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    wait_rdy(0, 2000, cyc);
    checks++; if (cyc !== 533) begin errors++; $display("FAIL fresh_latency got %0d want 533", cyc); end
    drain(nobs, nexp, nbad, got, want);
    checks++; if (nbad !== 0 || nobs !== nexp) begin errors++; $display("FAIL fresh_data got %h want %h (bad %0d, writes %0d/%0d)", got, want, nbad, nobs, nexp); end
  endtask

  task automatic test_back_to_back();
    int cyc, nobs, nexp, nbad;
    logic [17:0] got, want;
    load_ct(2, V_ATK_CT, 15);
    push_exp(2, V_ATK_PT, 15);
    key6 = "Secret";
    en[2] = 1'b1;
    tick();
    wait_rdy(2, 2000, cyc);
    checks++; if (cyc !== 543) begin errors++; $display("FAIL b2b_first_latency got %0d want 543", cyc); end
    // Second run: "KeyKey" schedules the same as the 3-byte key "Key".
    key6 = "KeyKey";
    load_ct(2, V_KEY_CT, 10);
    push_exp(2, V_KEY_PT, 10);
    tick();
    checks++; if (rdy[2] !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got rdy=%b want 0", rdy[2]); end
    en[2] = 1'b0;
    wait_rdy(2, 2000, cyc);
    checks++; if (cyc !== 533) begin errors++; $display("FAIL b2b_second_latency got %0d want 533", cyc); end
    drain(nobs, nexp, nbad, got, want);
    checks++; if (nobs !== 25 || nexp !== 25) begin errors++; $display("FAIL b2b_writes got %0d want 25", nobs); end
    checks++; if (nbad !== 0) begin errors++; $display("FAIL b2b_data got %h want %h (bad %0d)", got, want, nbad); end
  endtask

  initial begin
    rst = 1'b0;
    key3 = '0;
    key4 = '0;
    key6 = '0;
    for (int n = 0; n < 3; n++) begin
      en[n] = 1'b0;
      ct_max[n] = 0;
      for (int b = 0; b < 256; b++) ct_mem[n][b] = 8'h00;
    end
    #2;
    test_reset();
    test_plaintext();
    test_pedia();
    test_attack();
    test_zero_len();
    test_wrong_key();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
